bandit: RTL and testbench
=========================

Name: bandit

Overview:
- Epsilon-greedy multi-armed bandit agent with 256 arms.
- Holds a 256-entry table of signed 8-bit action values and selects an arm: greedy argmax by default, random with probability about EPSILON/256.
- Emits the chosen arm on a ready/valid action stream, waits for a signed reward on a ready/valid reward stream, then updates that arm's value.
- Sits between a stimulus/environment block and the rest of the learning system; one episode per action/reward pair.

Parameters:
- ACTION_WIDTH, 8, arm index width; table depth = 2**ACTION_WIDTH.
- VALUE_WIDTH, 8, signed width of table entries and reward.
- STEP_SHIFT, 2, learning rate alpha = 2**-STEP_SHIFT.
- EPSILON, 8, exploration threshold against an 8-bit random byte; 0 disables exploration.
- LFSR_SEED, 16'hACE1, nonzero LFSR reset value.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- action_valid  out  1  chosen arm available on action_data.
- action_data  out  8  chosen arm index.
- action_ready  in  1  consumer accepts action.
- reward_valid  in  1  reward_data is valid.
- reward_data  in  8  signed reward for the last emitted action.
- reward_ready  out  1  block is waiting for a reward.

Behaviour:
- Storage: unpacked array named action_value_table [0:255] of logic signed [7:0].
- The table is not touched by reset and has no initial clearing, so it may be preloaded hierarchically or with $readmem before or during reset. Reads are combinational.
- Reset: state=SELECT, action_valid=0, reward_ready=0, action_data=0, scan index=0, best=0, LFSR=LFSR_SEED. Reset mid-episode abandons the episode and leaves the table intact.
- Random source: 16-bit Fibonacci LFSR, taps 16,14,13,11. It advances every cycle, never 0.
- FSM states are SELECT, ACTION, REWARD, UPDATE.
- SELECT:
  - Scans indices 0..255, one per cycle, tracking best index and value.
  - Replaces best only on strictly greater value, so ties go to the lowest index.
  - After index 255 (256 cycles), if LFSR[7:0] < EPSILON, action = LFSR[15:8]; else action = best.
  - Registers action_data, sets action_valid=1, goes to ACTION.
- ACTION: holds action_valid=1 and action_data stable. On posedge with action_ready=1, clears action_valid, sets reward_ready=1, goes to REWARD.
- REWARD: holds reward_ready=1. On posedge with reward_valid=1, latches reward_data, clears reward_ready, goes to UPDATE.
- UPDATE (1 cycle):
  - delta = reward - Q[a], computed in 9-bit signed.
  - Q[a] <= sat8(Q[a] + (delta >>> STEP_SHIFT)), with arithmetic shift (floor).
  - Saturate to [-128, 127].
  - Return to SELECT with scan index 0.
- action_valid and reward_ready are never high together.
- Each output is asserted only in its own state.
- Latency: action_valid rises 257 cycles after reset release or after UPDATE.
- Rewards presented outside REWARD are ignored (reward_ready=0).

Decomposition:
- Package bandit_pkg holds:
  - state_t enum {SELECT, ACTION, REWARD, UPDATE};
  - action_t (logic [7:0]);
  - value_t (logic signed [7:0]);
  - the saturating-update function.
- One sub-module, bandit_lfsr: 16-bit LFSR with seed parameter, clock, reset, and 16-bit state output.
- Table, scan, and FSM live in bandit.

Test Plan:
- EPSILON=0, table all 5, rewards all 0, action_ready=1:
  - First action = 0, arriving 257 cycles after reset.
  - After reward 0, table[0] = 3 (5 + (-5>>>2) = 5 - 2).
  - Next action = 1.
- EPSILON=0, table all 5, reward 3 only for arm 64, 100 episodes:
  - Arms 0..99 each chosen once, in order.
  - Arm 64 ends at 4; the other visited arms end at 3; arms 100..255 stay 5.
- Repeated reward 0 on a single arm starting from 5: values 3, 2, 1, 0, 0 — no underflow below 0.
- Saturation:
  - Q = 127, reward 127: Q stays 127.
  - Q = -128, reward -128: Q stays -128.
  - Q = -128, reward 127: Q = -128 + 63 = -65.
- Backpressure:
  - action_ready held 0 for 10 cycles: action_valid and action_data stay stable.
  - reward_valid pulsed while in ACTION: ignored.
  - Reset asserted in REWARD: outputs return to 0, table unchanged, new selection starts.
- EPSILON=255, LFSR_SEED known: the first action equals the LFSR's upper byte at the end of the scan, checked against a reference LFSR model.

Source files
------------

// File: rtl/bandit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bandit_pkg                                                 |
// | Purpose  : Shared types and the saturating value-update function for  |
// |            the epsilon-greedy bandit agent.                           |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package bandit_pkg;

  typedef enum logic [1:0] {
    SELECT = 2'd0,
    ACTION = 2'd1,
    REWARD = 2'd2,
    UPDATE = 2'd3
  } state_t;

  typedef logic [7:0]        action_t;
  typedef logic signed [7:0] value_t;

  // Q + ((r - Q) >>> shift), clamped to the signed 8-bit range.
  // The difference needs 9 bits; the sum needs 10 to see overflow.
  function automatic value_t sat_update(input value_t q, input value_t r,
                                        input int unsigned shift);
    logic signed [8:0] delta;
    logic signed [8:0] step;
    logic signed [9:0] sum;
    delta = $signed({r[7], r}) - $signed({q[7], q});
    step  = delta >>> shift;
    sum   = $signed({step[8], step}) + $signed({{2{q[7]}}, q});
    if (sum > 10'sd127) begin
      return 8'sd127;
    end else if (sum < -10'sd128) begin
      return -8'sd128;
    end else begin
      return sum[7:0];
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/bandit_lfsr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bandit_lfsr                                                |
// | Purpose  : 16-bit Fibonacci LFSR (taps 16,14,13,11), free running,    |
// |            used as the exploration random source.                    |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module bandit_lfsr #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] state
);

  logic feedback;

  assign feedback = state[15] ^ state[13] ^ state[12] ^ state[10];

  // Advance once per cycle; a nonzero seed keeps the sequence off zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= LFSR_SEED;
    end else begin
      state <= {state[14:0], feedback};
    end
  end

endmodule
`default_nettype wire

// File: rtl/bandit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bandit                                                     |
// | Purpose  : Epsilon-greedy multi-armed bandit agent. Scans the value   |
// |            table for the greedy arm, optionally explores, emits the   |
// |            arm, waits for a reward and updates that arm's value.      |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module bandit
  import bandit_pkg::*;
#(
  parameter int          ACTION_WIDTH = 8,
  parameter int          VALUE_WIDTH  = 8,
  parameter int          STEP_SHIFT   = 2,
  parameter int          EPSILON      = 8,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic                    action_valid,
  output logic [ACTION_WIDTH-1:0] action_data,
  input  logic                    action_ready,
  input  logic                    reward_valid,
  input  logic [VALUE_WIDTH-1:0]  reward_data,
  output logic                    reward_ready
);

  localparam int         DEPTH     = 2**ACTION_WIDTH;
  localparam logic [8:0] EPS_LIMIT = 9'(EPSILON);

  // Not reset: contents survive reset and may be preloaded externally.
  logic signed [VALUE_WIDTH-1:0] action_value_table [0:DEPTH-1];

  state_t                        state;
  // One extra bit: the MSB marks the decision cycle after the last index.
  logic [ACTION_WIDTH:0]         scan_idx;
  logic [ACTION_WIDTH-1:0]       best_idx;
  logic signed [VALUE_WIDTH-1:0] best_val;
  logic signed [VALUE_WIDTH-1:0] reward_q;
  logic [15:0]                   lfsr;

  logic [ACTION_WIDTH-1:0]       scan_addr;
  logic signed [VALUE_WIDTH-1:0] scan_val;
  logic                          scan_done;
  logic                          explore;
  logic signed [VALUE_WIDTH-1:0] cur_val;
  logic signed [VALUE_WIDTH-1:0] next_val;

  bandit_lfsr #(
    .LFSR_SEED (LFSR_SEED)
  ) u_lfsr (
    .clock (clock),
    .reset (reset),
    .state (lfsr)
  );

  assign scan_addr = scan_idx[ACTION_WIDTH-1:0];
  assign scan_val  = action_value_table[scan_addr];
  assign scan_done = scan_idx[ACTION_WIDTH];
  assign explore   = ({1'b0, lfsr[7:0]} < EPS_LIMIT);
  assign cur_val   = action_value_table[action_data];
  assign next_val  = sat_update(cur_val, reward_q, unsigned'(STEP_SHIFT));

  // Episode controller: scan, emit action, wait for reward, update.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= SELECT;
      action_valid <= 1'b0;
      reward_ready <= 1'b0;
      action_data  <= '0;
      scan_idx     <= '0;
      best_idx     <= '0;
      best_val     <= '0;
      reward_q     <= '0;
    end else begin
      case (state)
        SELECT: begin
          if (!scan_done) begin
            // Index 0 always seeds the search; later entries must be
            // strictly greater, so ties resolve to the lowest index.
            if (scan_idx == '0 || scan_val > best_val) begin
              best_idx <= scan_addr;
              best_val <= scan_val;
            end
            scan_idx <= scan_idx + 1'b1;
          end else begin
            action_data  <= explore ? lfsr[8 +: ACTION_WIDTH] : best_idx;
            action_valid <= 1'b1;
            state        <= ACTION;
          end
        end
        ACTION: begin
          if (action_ready) begin
            action_valid <= 1'b0;
            reward_ready <= 1'b1;
            state        <= REWARD;
          end
        end
        REWARD: begin
          if (reward_valid) begin
            reward_q     <= reward_data;
            reward_ready <= 1'b0;
            state        <= UPDATE;
          end
        end
        UPDATE: begin
          scan_idx <= '0;
          state    <= SELECT;
        end
        default: begin
          state <= SELECT;
        end
      endcase
    end
  end

  // Value write-back happens only in the single UPDATE cycle.
  always_ff @(posedge clock) begin
    if (!reset && state == UPDATE) begin
      action_value_table[action_data] <= next_val;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bandit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_bandit                                                  |
// | Purpose  : Self-checking bench for the bandit agent with a high-level |
// |            value/argmax model and directed episodes.                  |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_bandit;

  logic       clock = 1'b0;
  logic       reset = 1'b1;

  logic       av1, rr1, ready1, rvalid1;
  logic [7:0] ad1, rdata1;
  logic       av2, rr2, ready2, rvalid2;
  logic [7:0] ad2, rdata2;

  int errors = 0;
  int checks = 0;
  int model_q [256];
  int exp_action = 0;
  bit cmp_en = 1'b0;

  always #5 clock = ~clock;

  bandit #(.EPSILON(0)) dut (
    .clock(clock), .reset(reset),
    .action_valid(av1), .action_data(ad1), .action_ready(ready1),
    .reward_valid(rvalid1), .reward_data(rdata1), .reward_ready(rr1)
  );

  bandit #(.EPSILON(255), .LFSR_SEED(16'hACE1)) dut_explore (
    .clock(clock), .reset(reset),
    .action_valid(av2), .action_data(ad2), .action_ready(ready2),
    .reward_valid(rvalid2), .reward_data(rdata2), .reward_ready(rr2)
  );

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Greedy choice: first arm holding the maximum value.
  function automatic int argmax();
    int best = 0;
    for (int i = 1; i < 256; i++) if (model_q[i] > model_q[best]) best = i;
    return best;
  endfunction

  // Q + floor((r - Q) / 4), clamped to [-128, 127].
  function automatic int model_update(input int q, input int r);
    int d, s, v;
    d = r - q;
    s = (d >= 0) ? d / 4 : -((-d + 3) / 4);
    v = q + s;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic int dut_q(input int i);
    return int'(dut.action_value_table[i]);
  endfunction

  task automatic set_q(input int i, input int v);
    dut.action_value_table[i] = 8'(v);
    model_q[i] = v;
  endtask

  // Every cycle: streams exclusive, and any offered arm matches the model.
  always @(negedge clock) begin
    if (cmp_en && !reset) begin
      check("exclusive_handshake", int'(av1 && rr1), 0);
      if (av1) check("action_stream", int'(ad1), exp_action);
    end
  end

  task automatic do_reset(input int n);
    reset = 1'b1; ready1 = 1'b1; rvalid1 = 1'b0; rdata1 = 8'd0;
    repeat (n) @(negedge clock);
    check("rst_action_valid", int'(av1), 0);
    check("rst_reward_ready", int'(rr1), 0);
    check("rst_action_data", int'(ad1), 0);
    reset = 1'b0;
  endtask

  task automatic wait_action(output int cyc);
    cyc = 0;
    while (!av1 && cyc < 1000) begin
      @(negedge clock);
      cyc++;
    end
    if (!av1) check("action_timeout", 0, 1);
  endtask

  task automatic finish_episode(input int reward, input int act);
    int cyc = 0;
    @(negedge clock);
    while (!rr1 && cyc < 100) begin
      @(negedge clock);
      cyc++;
    end
    if (!rr1) check("reward_ready_timeout", 0, 1);
    rdata1 = 8'(reward); rvalid1 = 1'b1;
    @(negedge clock);
    rvalid1 = 1'b0; rdata1 = 8'd0;
    check("reward_ready_drop", int'(rr1), 0);
    model_q[act] = model_update(model_q[act], reward);
    @(negedge clock);
    check("table_update", dut_q(act), model_q[act]);
  endtask

  task automatic episode(input int reward, output int act, output int cyc);
    exp_action = argmax();
    wait_action(cyc);
    act = int'(ad1);
    finish_episode(reward, act);
  endtask

  initial begin
    int cyc, act, snap;
    logic [15:0] s;
    int exp2;
    ready1 = 1'b1; rvalid1 = 1'b0; rdata1 = 8'd0;
    ready2 = 1'b0; rvalid2 = 1'b0; rdata2 = 8'd0;

    // Phase 1: all values 5, greedy, zero rewards.
    for (int i = 0; i < 256; i++) begin
      set_q(i, 5);
      dut_explore.action_value_table[i] = 8'sd5;
    end
    do_reset(3);
    cmp_en = 1'b1;
    exp_action = argmax();
    wait_action(cyc);
    check("first_latency", cyc, 257);
    check("first_action", int'(ad1), 0);

    // Exploring instance: arm comes from the LFSR upper byte.
    s = 16'hACE1;
    repeat (256) s = lfsr_next(s);
    exp2 = (s[7:0] < 8'd255) ? int'(s[15:8]) : 0;
    check("explore_valid", int'(av2), 1);
    check("explore_action", int'(ad2), exp2);

    finish_episode(0, 0);
    check("q0_after_zero_reward", dut_q(0), 3);
    check("model_pin_q0", model_q[0], 3);

    for (int ep = 1; ep < 100; ep++) begin
      episode((ep == 64) ? 3 : 0, act, cyc);
      check("arm_order", act, ep);
      if (ep == 1) check("episode_latency", cyc, 257);
    end
    check("q64_literal", dut_q(64), 4);
    check("q99_literal", dut_q(99), 3);
    check("q100_literal", dut_q(100), 5);
    check("q255_literal", dut_q(255), 5);
    for (int i = 0; i < 256; i++) check("table_sweep", dut_q(i), model_q[i]);

    // Phase 2: one live arm decays toward 0 and stops there.
    reset = 1'b1;
    for (int i = 0; i < 256; i++) set_q(i, -128);
    set_q(7, 5);
    do_reset(2);
    begin
      int decay [5] = '{3, 2, 1, 0, 0};
      for (int k = 0; k < 5; k++) begin
        episode(0, act, cyc);
        check("decay_arm", act, 7);
        check("decay_value", dut_q(7), decay[k]);
      end
    end

    // Phase 3: saturation corners.
    reset = 1'b1;
    for (int i = 0; i < 256; i++) set_q(i, -128);
    set_q(3, 127);
    do_reset(2);
    episode(127, act, cyc);
    check("sat_hi_arm", act, 3);
    check("sat_hi_value", dut_q(3), 127);
    set_q(3, -128);
    episode(-128, act, cyc);
    check("sat_lo_arm", act, 0);
    check("sat_lo_value", dut_q(0), -128);
    episode(127, act, cyc);
    check("sat_jump_value", dut_q(0), -65);

    // Phase 4: action backpressure with a stray reward pulse.
    ready1 = 1'b0;
    exp_action = argmax();
    wait_action(cyc);
    snap = int'(ad1);
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin rvalid1 = 1'b1; rdata1 = 8'd100; end
      if (k == 4) begin rvalid1 = 1'b0; rdata1 = 8'd0; end
      @(negedge clock);
      check("hold_valid", int'(av1), 1);
      check("hold_data", int'(ad1), snap);
      check("hold_no_reward_ready", int'(rr1), 0);
    end
    ready1 = 1'b1;
    finish_episode(0, snap);
    check("backpressure_value", dut_q(0), -49);

    // Phase 5: reset while waiting for a reward.
    exp_action = argmax();
    wait_action(cyc);
    @(negedge clock);
    check("in_reward_state", int'(rr1), 1);
    do_reset(2);
    for (int i = 0; i < 256; i++) check("table_kept", dut_q(i), model_q[i]);
    exp_action = argmax();
    wait_action(cyc);
    check("post_reset_latency", cyc, 257);
    check("post_reset_action", int'(ad1), 0);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
